alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters, e.g. the execute stage and a
//  multi-cycle helper. Arbitrates round-robin and accepts requests with a valid/ready
//  handshake. Drives registered operands into the external ALU and returns a registered
//  result with a one-cycle done pulse to the winner. Sits between the requesters and
//  the ALU instance. The ALU itself is instantiated alongside, not inside, this block.
// PARAMETERS
//  WIDTH  8  operand/result width (signed two's complement)
//  OPW    4  ALU op-code width
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  req0    in   1      requester 0 valid; op0/a0/b0 stable while high
//  op0     in   OPW    requester 0 ALU op
//  a0      in   WIDTH  requester 0 operand a
//  b0      in   WIDTH  requester 0 operand b
//  gnt0    out  1      requester 0 ready; req0&gnt0 at clock edge = accepted
//  done0   out  1      one-cycle pulse: result holds requester 0's answer
//  req1/op1/a1/b1/gnt1/done1  same as port 0, for requester 1
//  alu_op  out  OPW    registered op to ALU
//  alu_a   out  WIDTH  registered operand a to ALU
//  alu_b   out  WIDTH  registered operand b to ALU
//  alu_z   in   WIDTH  ALU combinational result
//  result  out  WIDTH  registered result, held until next capture
//  busy    out  1      high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, alu_op/alu_a/alu_b=0, result=0, done0/done1=0, busy=0.
//  - FSM: IDLE -> EXEC (on acceptance) -> RESP -> IDLE. Fixed; no back-to-back accept.
//  - gnt0/gnt1 are combinational and can be high only in IDLE. At most one is high.
//  - IDLE arbitration:
//      only req0 -> gnt0; only req1 -> gnt1.
//      both high -> grant requester ptr (ptr=0 favours requester 0).
//  - On acceptance (edge ending cycle C):
//      latch winner's op/a/b into alu_op/alu_a/alu_b;
//      record winner id; ptr <= ~winner.
//      ptr is unchanged when there is no acceptance.
//  - Cycle C+1, EXEC: ALU settles on registered operands. At edge: result <= alu_z.
//  - Cycle C+2, RESP: done<id>=1 for exactly one cycle; the other done stays 0.
//  - Cycle C+3: IDLE again; a new grant is possible in this cycle.
//    Latency is accept-to-done 2 cycles; throughput is one op per 3 cycles.
//  - Requesters must drop req, or present new operands, the cycle after acceptance.
//    A req held high is treated as a new request at the next IDLE.
//  - Operands are captured once. Input changes during EXEC/RESP do not affect result.
//  - alu_op/a/b hold their last values outside EXEC. result is unchanged outside the
//    EXEC->RESP edge.
//  - Width: alu_z is taken as-is, WIDTH bits, no extension. Overflow is the ALU's
//    concern.
//  - Reset mid-operation (EXEC or RESP):
//      next cycle is IDLE with all reset values;
//      the pending done is never emitted and ptr returns to 0.
//  - rst has priority over any simultaneous request.
// TESTING
//  1. req0 op=2 a=5 b=-4 -> gnt0 same cycle; done0 2 cycles later; result=8'h01;
//     done1 stays 0.
//  2. req1 op=6 a=9 b=10 -> done1; result=8'hFF (-1). busy high for exactly 2 cycles.
//  3. req0 and req1 both held after reset; req0 op=0 21,3; req1 op=1 2,5:
//     gnt0 first, result=8'h01;
//     then gnt1 at the next IDLE, result=8'h07;
//     then gnt0 again (round-robin alternation).
//  4. req0 op=7 a=1 b=3 -> result=8'h01;
//     then req0 op=7 a=6 b=5 -> result=8'h00;
//     then req1 op=12 a=1 b=3 -> result=8'hFC.
//  5. Change a0 to 99 during EXEC of op=2 3+4 -> result still 8'h07.
//  6. Assert rst during EXEC -> no done pulse; next cycle busy=0, result=0;
//     simultaneous req0/req1 then grants requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two
// requesters: operands are registered toward the ALU and the result is registered back.
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [OPW-1:0]   op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             done0,
    input  logic             req1,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             done1,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_z,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [1:0]       req_vec;
    logic [1:0]       gnt_vec;
    logic [1:0]       done_vec;
    logic [OPW-1:0]   op_vec [2];
    logic [WIDTH-1:0] a_vec  [2];
    logic [WIDTH-1:0] b_vec  [2];
    logic             accept;
    logic             win_id;

    assign req_vec  = {req1, req0};
    assign op_vec[0] = op0;
    assign op_vec[1] = op1;
    assign a_vec[0]  = a0;
    assign a_vec[1]  = a1;
    assign b_vec[0]  = b0;
    assign b_vec[1]  = b1;

    // Grants exist only in IDLE; on contention the pointer picks the winner.
    always_comb begin
        gnt_vec = 2'b00;
        if (state_q == IDLE) begin
            if (&req_vec) begin
                gnt_vec[ptr_q] = 1'b1;
            end else begin
                gnt_vec = req_vec;
            end
        end
    end

    assign accept = |gnt_vec;
    assign win_id = gnt_vec[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign done_vec[gi] = (state_q == RESP) && (id_q == gi[0]);
        end
    endgenerate

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            id_q     <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured once at acceptance; result only on the EXEC->RESP edge.
    always_comb begin
        ptr_d    = ptr_q;
        id_d     = id_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;
        if (accept) begin
            id_d     = win_id;
            ptr_d    = ~win_id;
            alu_op_d = op_vec[win_id];
            alu_a_d  = a_vec[win_id];
            alu_b_d  = b_vec[win_id];
        end
        if (state_q == EXEC) begin
            result_d = alu_z;
        end
    end

    always_comb begin
        gnt0   = gnt_vec[0];
        gnt1   = gnt_vec[1];
        done0  = done_vec[0];
        done1  = done_vec[1];
        busy   = (state_q != IDLE);
        alu_op = alu_op_q;
        alu_a  = alu_a_q;
        alu_b  = alu_b_q;
        result = result_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a reference ALU drives alu_z, stimulus pushes expected
// responses into a scoreboard and a negedge monitor checks every done pulse.
module tb_alu_share_arbiter;

    localparam int WIDTH = 8;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [OPW-1:0]   op0 = '0, op1 = '0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             gnt0, gnt1, done0, done1, busy;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_z, result;

    typedef struct {
        bit         id;
        logic [7:0] val;
        int         cyc;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 12 NOR.
    always_comb begin
        case (alu_op)
            4'd0:    alu_z = alu_a & alu_b;
            4'd1:    alu_z = alu_a | alu_b;
            4'd2:    alu_z = alu_a + alu_b;
            4'd6:    alu_z = alu_a - alu_b;
            4'd7:    alu_z = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
            4'd12:   alu_z = ~(alu_a | alu_b);
            default: alu_z = 8'h00;
        endcase
    end

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
        .result(result), .busy(busy)
    );

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst) begin
            if (done0 || done1) begin
                checks++;
                if (done0 && done1) begin
                    failures++;
                    $display("FAIL done_both: done0=%0b done1=%0b, required only one", done0, done1);
                end else if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: done0=%0b done1=%0b result=%h, required no done", done0, done1, result);
                end else begin
                    sb_entry_t e;
                    e = sb_q.pop_front();
                    if (done1 !== e.id || result !== e.val || (cyc - e.cyc) != 2) begin
                        failures++;
                        $display("FAIL done_resp: id=%0b result=%h latency=%0d, required id=%0b result=%h latency=2",
                                 done1, result, cyc - e.cyc, e.id, e.val);
                    end else begin
                        $display("resp id=%0b result=%h latency=%0d", done1, result, cyc - e.cyc);
                    end
                end
            end
            if (busy) begin
                checks++;
                if (gnt0 || gnt1) begin
                    failures++;
                    $display("FAIL gnt_while_busy: gnt0=%0b gnt1=%0b, required 0 0", gnt0, gnt1);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Waits up to max_wait negedges for a grant, checks it, optionally records the
    // expected response, then returns just after the accepting edge.
    task automatic wait_grant(input bit id, input logic [7:0] val, input bit push, input int max_wait);
        bit got = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL grant_timeout: no grant within %0d cycles, required gnt%0d", max_wait, id);
        end else if (gnt0 !== !id || gnt1 !== id) begin
            failures++;
            $display("FAIL grant_id: gnt0=%0b gnt1=%0b, required gnt%0d only", gnt0, gnt1, id);
        end else begin
            $display("grant id=%0d expect=%h", id, val);
            if (push) sb_q.push_back('{id: id, val: val, cyc: cyc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit id, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] val, output int busy_n);
        if (id) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        wait_grant(id, val, 1'b1, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(busy_n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_alu_ops", {12'd0, alu_op, alu_a, alu_b}, 32'd0);
        @(posedge clk);
        #1;

        // 1, 2: single requesters, ADD and SUB.
        do_req(1'b0, 4'd2, 8'd5, 8'hFC, 8'h01, n);
        do_req(1'b1, 4'd6, 8'd9, 8'd10, 8'hFF, n);
        check("busy_cycles", n, 32'd2);

        // 3: both held after reset -> alternate 0, 1, 0.
        do_reset();
        req0 = 1'b1; op0 = 4'd0; a0 = 8'd21; b0 = 8'd3;
        req1 = 1'b1; op1 = 4'd1; a1 = 8'd2;  b1 = 8'd5;
        wait_grant(1'b0, 8'h01, 1'b1, 1);
        wait_grant(1'b1, 8'h07, 1'b1, 4);
        wait_grant(1'b0, 8'h01, 1'b1, 4);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(n);

        // 4: SLT true, SLT false, NOR.
        do_req(1'b0, 4'd7, 8'd1, 8'd3, 8'h01, n);
        do_req(1'b0, 4'd7, 8'd6, 8'd5, 8'h00, n);
        do_req(1'b1, 4'd12, 8'd1, 8'd3, 8'hFC, n);

        // 5: operand change during EXEC is ignored.
        req0 = 1'b1; op0 = 4'd2; a0 = 8'd3; b0 = 8'd4;
        wait_grant(1'b0, 8'h07, 1'b1, 1);
        req0 = 1'b0;
        a0 = 8'd99;
        wait_idle(n);
        check("result_hold", {24'd0, result}, 32'h07);

        // 6: reset during EXEC cancels the response and restores ptr to 0.
        req0 = 1'b1; op0 = 4'd2; a0 = 8'd1; b0 = 8'd1;
        wait_grant(1'b0, 8'h02, 1'b0, 1);
        req0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_result", {24'd0, result}, 32'd0);
        check("midrst_alu_a", {24'd0, alu_a}, 32'd0);
        @(posedge clk);
        #1;
        req0 = 1'b1; op0 = 4'd2; a0 = 8'd2; b0 = 8'd3;
        req1 = 1'b1; op1 = 4'd6; a1 = 8'd2; b1 = 8'd3;
        wait_grant(1'b0, 8'h05, 1'b1, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(n);

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
